regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with LSU winning.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 alu_valid / alu_rd / alu_data  input  1/5/32  ALU writeback request.
REQ-005 alu_ready  output  1  ALU request accepted this cycle.
REQ-006 lsu_valid / lsu_rd / lsu_data  input  1/5/32  load-unit writeback request.
REQ-007 lsu_ready  output  1  LSU request accepted this cycle.
REQ-008 ld_issue / ld_issue_rd  input  1/5  load issued; its rd becomes pending.
REQ-009 chk_rs1 / chk_rs2  input  5/5  decode-stage source registers to check.
REQ-010 hazard  output  1  a checked source is pending or being written next edge.
REQ-011 rf_we / rf_rd / rf_rd_data  output  1/5/32  registered regfile write port.
REQ-012 busy  output  32  pending-load scoreboard; bit 0 always 0.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 A request is accepted when valid && ready in the same cycle; ready is combinational from valids, rd, busy and the arbitration pointer.
REQ-015 At most one of alu_ready/lsu_ready SHALL be high per cycle.
REQ-016 alu_ready SHALL be low while busy[alu_rd]=1 (WAW block); lsu_ready is never blocked by busy.
REQ-017 Both eligible, RR_EN=1: grant goes to the requester not granted last; pointer updates only on an accept.
REQ-018 Both eligible, RR_EN=0: LSU granted.
REQ-019 Single eligible requester is granted regardless of the pointer.
REQ-020 Accept in cycle N -> rf_we=1, rf_rd, rf_rd_data valid in cycle N+1; no accept -> rf_we=0 in N+1, rf_rd/rf_rd_data hold.
REQ-021 Accepted request with rd=0 SHALL complete the handshake but produce rf_we=0.
REQ-022 ld_issue with ld_issue_rd!=0 sets busy[ld_issue_rd] at next edge; rd=0 ignored.
REQ-023 An accepted LSU write clears busy[lsu_rd] at next edge.
REQ-024 Same-cycle set and clear of the same rd: set wins (busy stays 1).
REQ-025 hazard = busy[chk_rs1] | busy[chk_rs2] | (rf_we && rf_rd!=0 && rf_rd matches chk_rs1 or chk_rs2); index 0 never hazards.
REQ-026 err set at next edge and held until reset on: ld_issue to an already-busy rd with no same-cycle clear, or an accepted LSU write to a non-busy rd!=0.
REQ-027 Inputs are sampled only when valid; rd/data changes while valid is low have no effect.

Reset
REQ-028 rst asserted: busy=0, err=0, rf_we=0, rf_rd=0, rf_rd_data=0, pointer=ALU-last (LSU wins first tie), immediately and asynchronously.
REQ-029 Requests presented during reset are not accepted; alu_ready=lsu_ready=0 while rst=1.
REQ-030 Reset mid-operation discards the registered write in flight; no rf_we pulse after deassertion without a new accept.

Structure
REQ-031 Shared package rf_pkg holds REG_W=32, REG_N=32, REG_IDX_W=5 and a two-value requester enum {REQ_ALU, REQ_LSU}.
REQ-032 Scoreboard (busy vector, set/clear, err detection) is a sub-module named rf_scoreboard; arbitration and output register remain in regfile_wb_ctrl.

Verification
REQ-033 Both valid every cycle, RR_EN=1, alu_rd=3, lsu_rd=4 (busy[4]=1 via ld_issue, re-issued after each write) -> grants alternate LSU,ALU,LSU..., rf_rd alternates 4,3 one cycle later.
REQ-034 ld_issue rd=5, then alu_valid rd=5 data=0xAAAA -> alu_ready=0 until LSU write rd=5 data=0x1234 accepted; rf writes 0x1234 then 0xAAAA in order.
REQ-035 ld_issue rd=7, chk_rs1=7 -> hazard=1 from next cycle; LSU write rd=7 accepted -> hazard stays 1 through the rf_we cycle, 0 after.
REQ-036 alu_valid rd=0 data=0xFFFFFFFF -> alu_ready=1, rf_we stays 0; chk_rs1=0 -> hazard=0.
REQ-037 ld_issue rd=9 twice without writeback -> err=1 persisting; same-cycle ld_issue rd=9 and LSU write rd=9 -> busy[9]=1, err=0.
REQ-038 rst asserted mid-stream the cycle after an accept -> rf_we=0 immediately, busy=0, err=0; first tie after release granted to LSU.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared register-file widths and writeback requester encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_W     = 32;
    localparam int REG_N     = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Pending-load busy vector with set/clear and sticky protocol error.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_issue_i,
    input  logic [REG_IDX_W-1:0] ld_issue_rd_i,
    input  logic                 lsu_acc_i,
    input  logic [REG_IDX_W-1:0] lsu_rd_i,
    output logic [REG_N-1:0]     busy_o,
    output logic                 err_o
);

    logic [REG_N-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic             set_w, clr_w, same_w;

    always_comb begin
        set_w  = ld_issue_i && (ld_issue_rd_i != '0);
        clr_w  = lsu_acc_i && (lsu_rd_i != '0);
        same_w = set_w && clr_w && (ld_issue_rd_i == lsu_rd_i);

        busy_d = busy_q;
        // Clear first so a same-cycle set on the same index takes precedence.
        if (clr_w) busy_d[lsu_rd_i] = 1'b0;
        if (set_w) busy_d[ld_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q;
        if (set_w && busy_q[ld_issue_rd_i] && !same_w) err_d = 1'b1;
        if (clr_w && !busy_q[lsu_rd_i])                err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl
// Brief    : ALU/LSU writeback arbiter with registered regfile write port,
//            pending-load scoreboard and decode hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
    import rf_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [REG_W-1:0]     alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [REG_W-1:0]     lsu_data,
    output logic                 lsu_ready,
    input  logic                 ld_issue,
    input  logic [REG_IDX_W-1:0] ld_issue_rd,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [REG_W-1:0]     rf_rd_data,
    output logic [REG_N-1:0]     busy,
    output logic                 err
);

    req_e                 last_q, last_d;
    logic                 rf_we_q, rf_we_d;
    logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
    logic [REG_W-1:0]     rf_data_q, rf_data_d;

    logic                 alu_elig_w, lsu_elig_w;
    logic                 grant_alu_w, grant_lsu_w;
    logic                 alu_acc_w, lsu_acc_w;
    logic [REG_N-1:0]     busy_w;
    logic                 err_w;

    // Arbitration: the ALU is held off while its destination awaits a load.
    always_comb begin
        alu_elig_w  = alu_valid && !busy_w[alu_rd] && !rst;
        lsu_elig_w  = lsu_valid && !rst;
        grant_lsu_w = lsu_elig_w && (!alu_elig_w || !RR_EN || (last_q == REQ_ALU));
        grant_alu_w = alu_elig_w && !grant_lsu_w;
        alu_acc_w   = grant_alu_w && alu_valid;
        lsu_acc_w   = grant_lsu_w && lsu_valid;
    end

    always_comb begin
        last_d    = last_q;
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (lsu_acc_w) begin
            last_d = REQ_LSU;
            if (lsu_rd != '0) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = lsu_rd;
                rf_data_d = lsu_data;
            end
        end else if (alu_acc_w) begin
            last_d = REQ_ALU;
            if (alu_rd != '0) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = alu_rd;
                rf_data_d = alu_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= REQ_ALU;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            last_q    <= last_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .ld_issue_i    (ld_issue),
        .ld_issue_rd_i (ld_issue_rd),
        .lsu_acc_i     (lsu_acc_w),
        .lsu_rd_i      (lsu_rd),
        .busy_o        (busy_w),
        .err_o         (err_w)
    );

    // A write landing this cycle is not yet visible in the regfile read path.
    always_comb begin
        hazard = busy_w[chk_rs1] | busy_w[chk_rs2] |
                 (rf_we_q && (rf_rd_q != '0) &&
                  ((rf_rd_q == chk_rs1) || (rf_rd_q == chk_rs2)));
    end

    assign alu_ready  = grant_alu_w;
    assign lsu_ready  = grant_lsu_w;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_rd_data = rf_data_q;
    assign busy       = busy_w;
    assign err        = err_w;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Brief    : Directed self-checking bench for regfile_wb_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, ld_issue;
    logic [4:0]  alu_rd, lsu_rd, ld_issue_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_data, lsu_data;

    logic        alu_ready, lsu_ready, hazard, rf_we, err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_data, busy;

    logic        fp_alu_ready, fp_lsu_ready, fp_hazard, fp_rf_we, fp_err;
    logic [4:0]  fp_rf_rd;
    logic [31:0] fp_rf_rd_data, fp_busy;

    int checks   = 0;
    int failures = 0;

    regfile_wb_ctrl #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
        .busy(busy), .err(err)
    );

    regfile_wb_ctrl #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(fp_lsu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(fp_hazard),
        .rf_we(fp_rf_we), .rf_rd(fp_rf_rd), .rf_rd_data(fp_rf_rd_data),
        .busy(fp_busy), .err(fp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        ld_issue  = 1'b0; ld_issue_rd = '0;
        chk_rs1   = '0;   chk_rs2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Requests during reset must be refused.
        alu_valid = 1'b1; alu_rd = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd4;
        tick();
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_rf_data", rf_rd_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        idle_inputs();
        rst = 1'b0;
        tick();

        // Alternating round-robin with ALU rd=3 and LSU rd=4.
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        tick();
        ld_issue = 1'b0;
        chk("rr_busy4", busy, 32'h0000_0010);
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA300_0000 + k;
            lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB400_0000 + k;
            ld_issue  = (k % 2 == 0); ld_issue_rd = 5'd4;
            #1;
            chk($sformatf("rr_lsu_ready_%0d", k), {31'd0, lsu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_alu_ready_%0d", k), {31'd0, alu_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 1) begin
                chk("fp_lsu_ready", {31'd0, fp_lsu_ready}, 32'd1);
                chk("fp_alu_ready", {31'd0, fp_alu_ready}, 32'd0);
            end
            if (k > 0) begin
                chk($sformatf("rr_rf_rd_%0d", k), {27'd0, rf_rd}, ((k - 1) % 2 == 0) ? 32'd4 : 32'd3);
                chk($sformatf("rr_rf_we_%0d", k), {31'd0, rf_we}, 32'd1);
            end
            tick();
        end
        idle_inputs();
        #1;
        chk("rr_last_rf_rd", {27'd0, rf_rd}, 32'd3);
        chk("rr_last_rf_data", rf_rd_data, 32'hA300_0003);
        chk("rr_busy_kept", busy, 32'h0000_0010);
        chk("rr_no_err", {31'd0, err}, 32'd0);
        tick();
        chk("rr_idle_we", {31'd0, rf_we}, 32'd0);
        chk("rr_hold_data", rf_rd_data, 32'hA300_0003);

        // WAW block: ALU rd=5 waits for the pending load to rd=5.
        do_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd5;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_AAAA;
        #1;
        chk("waw_blocked_0", {31'd0, alu_ready}, 32'd0);
        tick();
        chk("waw_blocked_1", {31'd0, alu_ready}, 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h0000_1234;
        #1;
        chk("waw_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("waw_alu_still", {31'd0, alu_ready}, 32'd0);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("waw_wr1_we", {31'd0, rf_we}, 32'd1);
        chk("waw_wr1_rd", {27'd0, rf_rd}, 32'd5);
        chk("waw_wr1_data", rf_rd_data, 32'h0000_1234);
        chk("waw_alu_free", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("waw_wr2_data", rf_rd_data, 32'h0000_AAAA);
        chk("waw_wr2_we", {31'd0, rf_we}, 32'd1);
        tick();
        chk("waw_idle_we", {31'd0, rf_we}, 32'd0);
        chk("waw_hold", rf_rd_data, 32'h0000_AAAA);

        // Hazard tracking through load completion and the write cycle.
        do_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd7; chk_rs1 = 5'd7;
        #1;
        chk("hz_pre", {31'd0, hazard}, 32'd0);
        tick();
        ld_issue = 1'b0;
        chk("hz_busy_0", {31'd0, hazard}, 32'd1);
        tick();
        chk("hz_busy_1", {31'd0, hazard}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
        #1;
        chk("hz_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("hz_we_cycle", {31'd0, hazard}, 32'd1);
        chk("hz_busy_clr", busy, 32'd0);
        tick();
        chk("hz_after", {31'd0, hazard}, 32'd0);

        // Writes to x0 handshake but never reach the regfile.
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("x0_hazard", {31'd0, hazard}, 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("x0_no_we", {31'd0, rf_we}, 32'd0);
        chk("x0_hazard2", {31'd0, hazard}, 32'd0);

        // Error detection: double issue, then the same-cycle set/clear case.
        do_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        chk("err_first", {31'd0, err}, 32'd0);
        tick();
        ld_issue = 1'b0;
        chk("err_set", {31'd0, err}, 32'd1);
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
        #1;
        chk("same_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle_inputs();
        chk("same_busy9", busy, 32'h0000_0200);
        chk("same_no_err", {31'd0, err}, 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h0000_00CC;
        tick();
        lsu_valid = 1'b0;
        chk("err_nonbusy_wr", {31'd0, err}, 32'd1);

        // Asynchronous reset with a write in flight.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        ld_issue = 1'b1; ld_issue_rd = 5'd6;
        tick();
        idle_inputs();
        chk("mid_we_before", {31'd0, rf_we}, 32'd1);
        chk("mid_busy_before", busy, 32'h0000_0040);
        rst = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd6;
        #1;
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_alu_rdy", {31'd0, alu_ready}, 32'd0);
        chk("mid_rst_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_post_we", {31'd0, rf_we}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd6;
        #1;
        chk("mid_tie_lsu", {31'd0, lsu_ready}, 32'd1);
        chk("mid_tie_alu", {31'd0, alu_ready}, 32'd0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
